button_reader: RTL and testbench

Debounced push-button/switch input reader: the human-input counterpart of the enable-gated register-plus-LED indicator cells. A raw, asynchronous button level is synchronized, debounced by a 4-state FSM with a cycle counter, and turned into a stable level, one-cycle press/release pulses and an enable-gated toggle register that drives the board LED. It sits at the board edge between a mechanical button and the core logic.

---
 rtl/button_reader_pkg.sv | 17 +
 rtl/button_reader_if.sv | 28 ++
 rtl/button_reader_sync_2ff.sv | 22 ++
 rtl/button_reader.sv | 128 ++++++++++++
 tb/tb_button_reader.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/button_reader_pkg.sv
// Shared types and helpers for the debounced button reader.
// Holds the FSM state encoding and the debounce counter width calculation.
package button_reader_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Wide enough to hold the value DebounceCycles itself.
    function automatic int cnt_width(input int debounce_cycles);
        return (debounce_cycles < 1) ? 1 : $clog2(debounce_cycles + 1);
    endfunction

endpackage

// File: rtl/button_reader_if.sv
// Button reader signal bundle: raw button and toggle enable in,
// debounced level, edge pulses and LED toggle out.
interface button_reader_if;
    logic en_i;
    logic btn_i;
    logic pressed_o;
    logic press_o;
    logic release_o;
    logic toggle_o;

    modport slave (
        input  en_i,
        input  btn_i,
        output pressed_o,
        output press_o,
        output release_o,
        output toggle_o
    );

    modport master (
        output en_i,
        output btn_i,
        input  pressed_o,
        input  press_o,
        input  release_o,
        input  toggle_o
    );
endinterface

// File: rtl/button_reader_sync_2ff.sv
// Generic 1-bit two-flop synchronizer with synchronous reset to a
// configurable level; reusable for any asynchronous board input.
module sync_2ff #(
    parameter bit ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta <= ResetVal;
            q_o  <= ResetVal;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end
endmodule

// File: rtl/button_reader.sv
// Debounced button reader: polarity fix, synchronizer, debounce FSM and
// registered level / press / release / LED toggle outputs.
//
// state        | meaning
// IDLE         | button accepted as released
// PRESS_WAIT   | pressed samples seen, counting toward acceptance
// PRESSED      | button accepted as pressed
// RELEASE_WAIT | released samples seen, counting toward acceptance
module button_reader
    import button_reader_pkg::*;
#(
    parameter int DebounceCycles = 1000,
    parameter bit BtnActiveLow   = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    button_reader_if.slave   bus
);
    localparam int          CW  = cnt_width(DebounceCycles);
    localparam logic [31:0] DcU = 32'(DebounceCycles);

    logic          b;
    logic          s;
    logic          cnt_done;
    btn_state_e    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          pressed_q, pressed_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          toggle_q, toggle_d;

    assign b = bus.btn_i ^ BtnActiveLow;

    sync_2ff #(.ResetVal(1'b0)) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (b),
        .q_o   (s)
    );

    assign cnt_done = ({{(32-CW){1'b0}}, cnt} + 32'd1) == DcU;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            pressed_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            toggle_q  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            pressed_q <= pressed_d;
            press_q   <= press_d;
            release_q <= release_d;
            toggle_q  <= toggle_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        unique case (state)
            IDLE: begin
                if (s) begin
                    if (DebounceCycles == 1) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            PRESSED: begin
                if (!s) begin
                    if (DebounceCycles == 1) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Pulses fire only on genuine acceptance, not on a bounce back from a wait state.
    always_comb begin
        pressed_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
        press_d   = (state_d == PRESSED) && ((state == IDLE) || (state == PRESS_WAIT));
        release_d = (state_d == IDLE) && ((state == PRESSED) || (state == RELEASE_WAIT));
        toggle_d  = toggle_q ^ (press_d & bus.en_i);
    end

    assign bus.pressed_o = pressed_q;
    assign bus.press_o   = press_q;
    assign bus.release_o = release_q;
    assign bus.toggle_o  = toggle_q;
endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader: one instance with 4-cycle active-low
// debounce, one with 1-cycle active-high debounce.
module tb_button_reader;
    import button_reader_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    button_reader_if bus_a ();
    button_reader_if bus_b ();

    button_reader #(.DebounceCycles(4), .BtnActiveLow(1'b1)) dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    button_reader #(.DebounceCycles(1), .BtnActiveLow(1'b0)) dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    // {pressed, press, release, toggle}
    logic [3:0] obs_a, obs_b;
    assign obs_a = {bus_a.pressed_o, bus_a.press_o, bus_a.release_o, bus_a.toggle_o};
    assign obs_b = {bus_b.pressed_o, bus_b.press_o, bus_b.release_o, bus_b.toggle_o};

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1;
        bus_a.btn_i = 1'b1;
        bus_a.en_i  = 1'b1;
        bus_b.btn_i = 1'b0;
        bus_b.en_i  = 1'b1;
        tick(3);
        n_tests++;
        if (obs_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_a outputs got %b want 0000", obs_a);
        end
        n_tests++;
        if (obs_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_b outputs got %b want 0000", obs_b);
        end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (obs_a !== 4'b0000) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL idle_after_reset nonzero cycles got %0d want 0", bad);
        end
        n_tests++;
        if (dut_a.state !== IDLE) begin
            n_fail++;
            $display("FAIL idle_state got %0d want %0d", dut_a.state, IDLE);
        end
    endtask

    task automatic test_clean_press();
        bus_a.btn_i = 1'b0;
        tick(5);
        n_tests++;
        if (obs_a !== 4'b0000) begin
            n_fail++;
            $display("FAIL clean_press_early got %b want 0000", obs_a);
        end
        tick(1);
        n_tests++;
        if (obs_a !== 4'b1101) begin
            n_fail++;
            $display("FAIL clean_press_edge5 got %b want 1101", obs_a);
        end
        tick(1);
        n_tests++;
        if (obs_a !== 4'b1001) begin
            n_fail++;
            $display("FAIL clean_press_hold got %b want 1001", obs_a);
        end
    endtask

    task automatic test_bounce_press();
        int presses;
        int early;
        bus_a.btn_i = 1'b1;
        tick(12);
        n_tests++;
        if (obs_a !== 4'b0001) begin
            n_fail++;
            $display("FAIL bounce_setup_release got %b want 0001", obs_a);
        end
        presses = 0;
        early = 0;
        bus_a.btn_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (bus_a.press_o) early++;
        end
        bus_a.btn_i = 1'b1;
        tick(1);
        if (bus_a.press_o) early++;
        bus_a.btn_i = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick(1);
            if (bus_a.press_o) begin
                presses++;
                if (i != 6) early++;
            end
        end
        n_tests++;
        if (early != 0 || presses != 1) begin
            n_fail++;
            $display("FAIL bounce_press pulses got %0d (misplaced %0d) want 1 at cycle 6", presses, early);
        end
        n_tests++;
        if (obs_a !== 4'b1000) begin
            n_fail++;
            $display("FAIL bounce_press_final got %b want 1000", obs_a);
        end
    endtask

    task automatic test_release_bounce();
        int rel, prs, rel_at;
        bus_a.en_i = 1'b0;
        rel = 0;
        prs = 0;
        rel_at = -1;
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) bus_a.btn_i = 1'b1;
            if (i == 3) bus_a.btn_i = 1'b0;
            if (i == 4) bus_a.btn_i = 1'b1;
            tick(1);
            if (bus_a.release_o) begin
                rel++;
                rel_at = i;
            end
            if (bus_a.press_o) prs++;
        end
        n_tests++;
        if (rel != 1 || rel_at != 9) begin
            n_fail++;
            $display("FAIL release_bounce release pulses got %0d at %0d want 1 at 9", rel, rel_at);
        end
        n_tests++;
        if (prs != 0) begin
            n_fail++;
            $display("FAIL release_bounce extra press got %0d want 0", prs);
        end
        bus_a.btn_i = 1'b0;
        tick(6);
        n_tests++;
        if (obs_a !== 4'b1100) begin
            n_fail++;
            $display("FAIL press_en_low got %b want 1100", obs_a);
        end
    endtask

    task automatic test_reset_mid();
        int early;
        bus_a.btn_i = 1'b1;
        tick(12);
        bus_a.en_i = 1'b1;
        bus_a.btn_i = 1'b0;
        tick(4);
        n_tests++;
        if (dut_a.state !== PRESS_WAIT || dut_a.cnt !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_mid_setup got state %0d cnt %0d want 1 2", dut_a.state, dut_a.cnt);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        n_tests++;
        if (obs_a !== 4'b0000 || dut_a.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_mid_clear got %b state %0d want 0000 0", obs_a, dut_a.state);
        end
        early = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (bus_a.press_o) early++;
        end
        tick(1);
        n_tests++;
        if (early != 0 || obs_a !== 4'b1101) begin
            n_fail++;
            $display("FAIL reset_mid_press got %b (early %0d) want 1101", obs_a, early);
        end
    endtask

    task automatic test_param_corner();
        int prs, rel, order_bad, last;
        bus_b.btn_i = 1'b1;
        tick(2);
        n_tests++;
        if (obs_b !== 4'b0000) begin
            n_fail++;
            $display("FAIL corner_early got %b want 0000", obs_b);
        end
        tick(1);
        n_tests++;
        if (obs_b !== 4'b1101) begin
            n_fail++;
            $display("FAIL corner_press got %b want 1101", obs_b);
        end
        prs = 0;
        rel = 0;
        order_bad = 0;
        last = 1;
        for (int i = 0; i < 14; i++) begin
            if (i < 8) bus_b.btn_i = ((i / 2) % 2) == 1;
            else       bus_b.btn_i = 1'b0;
            tick(1);
            if (bus_b.press_o && bus_b.release_o) order_bad++;
            if (bus_b.press_o) begin
                prs++;
                if (last == 1) order_bad++;
                last = 1;
            end
            if (bus_b.release_o) begin
                rel++;
                if (last == 2) order_bad++;
                last = 2;
            end
        end
        n_tests++;
        if (prs != 2 || rel != 3 || order_bad != 0) begin
            n_fail++;
            $display("FAIL corner_alternate got press %0d release %0d order_err %0d want 2 3 0", prs, rel, order_bad);
        end
        n_tests++;
        if (bus_b.pressed_o !== 1'b0 || bus_b.toggle_o !== 1'b1) begin
            n_fail++;
            $display("FAIL corner_final got pressed %b toggle %b want 0 1", bus_b.pressed_o, bus_b.toggle_o);
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce_press();
        test_release_bounce();
        test_reset_mid();
        test_param_corner();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
